rp_mem_mp: RTL and testbench
============================

# rp_mem_mp

Multi-port shared memory for the rp core bench and small SoC builds. It is a parametrised successor of the single-port `mem` model: NP request/ack ports share one byte-addressed array. An arbiter with a selectable mode decides which port is served each cycle. Read data returns after a configurable pipeline latency. Typical use: program and data buses of `rp_core`, plus an optional DMA or loader port, on one memory.

## Interface
Parameters:
- NP, 2, number of ports (1..8)
- AW, 16, byte address width; array size is 2**AW bytes
- DW, 32, data width (8, 16, 32 or 64)
- SW, DW/8, byte select width
- LAT, 1, read latency in cycles from transfer to rdt update (1..4)
- ARB, RR, arbitration mode from the package enum: FIX (port 0 highest priority) or RR (round-robin)

Ports:
- clk  input  1  clock; all state is rising-edge
- rst  input  1  asynchronous reset, active low
- req  input  [NP]  request per port
- wen  input  [NP]  write enable (1 = write, 0 = read)
- sel  input  [NP][SW]  byte selects
- adr  input  [NP][AW]  byte address
- wdt  input  [NP][DW]  write data
- rdt  output [NP][DW]  read data
- ack  output [NP]  grant; a transfer occurs on port i when req[i] & ack[i]

## Operation
- ack is combinational from req and the arbiter state. It is one-hot or zero, and never set for a port with req low.
- FIX mode: the lowest-index requesting port wins.
- RR mode: the search starts at pointer ptr and wraps modulo NP. The first requesting port wins. After a grant to port g, ptr becomes (g+1) mod NP. ptr is unchanged when there is no grant.
- Word index is adr[AW-1:log2(SW)]. The low address bits are ignored. No misalignment checks.
- Write transfer: every byte with sel set is written at the transfer edge. Unselected bytes are unchanged.
- Read transfer: the word is read at the transfer edge, into pipeline stage 1. It travels through LAT stages, each carrying valid, port id and data. rdt[port] is loaded from the last stage.
- rdt[i] holds its value until the next read completion for port i.
- A read returns the full word regardless of sel.
- The read pipeline accepts one read every cycle. There is no backpressure on returned data.
- Read after write: a read transferred the cycle after a write to the same word, from any port, returns the new data.
- A write and a read can never be in the same cycle, because there is at most one transfer per cycle.
- Non-granted ports must hold req, wen, sel, adr and wdt stable until ack. The bench checks this and the block does not.

## Timing
- Reset (rst low, asynchronous):
  - ptr = 0
  - all pipeline valid bits = 0
  - all rdt = 0
  - memory contents are not reset
- ack is valid in the same cycle as req, so zero-wait grants are possible.
- Read latency: a transfer at edge t updates rdt at edge t+LAT. With LAT=1, data is visible the cycle after ack.
- Throughput: one transfer per cycle in total across all ports.
- RR fairness: with all NP ports requesting continuously, each port is granted exactly once every NP cycles.
- Reset mid-operation: in-flight reads are dropped and no rdt update occurs afterwards. Writes at an edge where reset is asserted are not performed.
- NP=1: the arbiter degenerates, ack = req, and ptr stays constant at 0.

## Structure
- Package rp_mem_pkg contains:
  - enum arb_t {FIX, RR}
  - a packed struct for a pipeline stage: vld, port id of width $clog2(NP) (minimum 1), and data
- Sub-module rp_arb (parameters NP and ARB; ports clk, rst, req, ack) holds ptr and the grant logic. It is reusable for future bus interconnect.
- Memory array: behavioural, with byte-lane writes, and initialised from a file only by the bench via a hierarchical preload task.

## Test plan
- Reset then idle: rst low for 3 cycles, then release. Required: ack=0, rdt=0 on all ports, ptr=0.
- Byte-lane write: port 0 writes 0xAABBCCDD to 0x0010 with sel=1111, then writes 0x11223344 with sel=0101. A port 1 read of 0x0010 must return 0xAA22CC44 at LAT cycles after its ack.
- RR contention: NP=3, all req held high for 9 cycles. The grant sequence must be 0,1,2,0,1,2,0,1,2. In FIX mode, port 0 must be granted on all 9 cycles.
- Latency sweep: with LAT set to 1, 2 and 4, issue back-to-back reads of 0x0000, 0x0004 and 0x0008, preloaded with 1, 2 and 3. rdt must update at edges t+LAT, t+1+LAT and t+2+LAT with 1, 2 and 3.
- Read after write: a port 1 write of 0xDEADBEEF to 0x0100 is followed next cycle by a port 0 read of 0x0100. The port 0 read must return 0xDEADBEEF.
- Reset mid-read: with LAT=3, issue a read and assert rst one cycle after ack. rdt must be 0 and stay 0 after rst is released.

Source files
------------

// File: rtl/rp_mem_mp_pkg.sv
// rp_mem_pkg: shared types and helpers for the rp_mem_mp multi-port memory.
//   arb_t : arbitration mode (FIX = port 0 highest priority, RR = round-robin)
//   id_w  : port id width for a given port count (minimum 1 bit)
// The pipeline stage struct depends on the NP/DW parameters of each instance,
// so rp_mem_mp declares it locally and sizes the id field with id_w().
package rp_mem_pkg;

  typedef enum logic {FIX, RR} arb_t;

  function automatic int id_w(input int np);
    return (np > 1) ? $clog2(np) : 1;
  endfunction

endpackage

// File: rtl/rp_mem_mp_if.sv
// rp_mem_mp_if: bundle of the per-port request/ack bus of rp_mem_mp.
//   req/wen/sel/adr/wdt : driven by the requesters (master)
//   rdt/ack             : driven by the memory (slave)
// Every field is a packed array indexed by port number.
interface rp_mem_mp_if #(
  parameter int NP = 2,
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int SW = DW / 8
);
  logic [NP-1:0]          req;
  logic [NP-1:0]          wen;
  logic [NP-1:0][SW-1:0]  sel;
  logic [NP-1:0][AW-1:0]  adr;
  logic [NP-1:0][DW-1:0]  wdt;
  logic [NP-1:0][DW-1:0]  rdt;
  logic [NP-1:0]          ack;

  modport master (output req, wen, sel, adr, wdt, input rdt, ack);
  modport slave  (input req, wen, sel, adr, wdt, output rdt, ack);
endinterface

// File: rtl/rp_mem_mp_arb.sv
// rp_arb: one-winner arbiter with fixed or round-robin priority.
//   clk : clock, rising edge
//   rst : asynchronous reset, active low (clears the round-robin pointer)
//   req : request per port
//   ack : one-hot or zero grant, combinational from req and ptr
module rp_arb
  import rp_mem_pkg::*;
#(
  parameter int   NP  = 2,
  parameter arb_t ARB = RR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NP-1:0] req,
  output logic [NP-1:0] ack
);

  localparam int PW = id_w(NP);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            win;
  int            start;

  // Search the ports in priority order starting at 'start' and wrapping;
  // the first requester wins. FIX always starts at port 0.
  always_comb begin
    ack   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    win   = 0;
    start = (ARB == RR) ? int'(ptr_q) : 0;
    for (int k = 0; k < NP; k++) begin
      for (int i = 0; i < NP; i++) begin
        if (!found && req[i] && (i == (start + k) % NP)) begin
          found = 1'b1;
          win   = i;
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      ack[i] = found && (win == i);
    end
    if (found && (ARB == RR)) begin
      ptr_d = PW'((win + 1) % NP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rp_mem_mp.sv
// rp_mem_mp: NP-port shared byte-addressed memory with arbitration and a
// LAT-stage read pipeline.
//   clk : clock, rising edge
//   rst : asynchronous reset, active low (clears ptr, pipeline and rdt;
//         memory contents are kept)
//   bus : rp_mem_mp_if slave port (req/wen/sel/adr/wdt in, rdt/ack out)
module rp_mem_mp
  import rp_mem_pkg::*;
#(
  parameter int   NP  = 2,
  parameter int   AW  = 16,
  parameter int   DW  = 32,
  parameter int   SW  = DW / 8,
  parameter int   LAT = 1,
  parameter arb_t ARB = RR
) (
  input  logic        clk,
  input  logic        rst,
  rp_mem_mp_if.slave  bus
);

  localparam int IDW = id_w(NP);
  localparam int OFS = $clog2(SW);
  localparam int WW  = AW - OFS;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic [DW-1:0]  dat;
  } stage_t;

  logic [NP-1:0]         ack;
  logic                  xfer;
  logic [IDW-1:0]        gidx;
  logic                  wen_g;
  logic [SW-1:0]         sel_g;
  logic [AW-1:0]         adr_g;
  logic [DW-1:0]         wdt_g;
  logic [WW-1:0]         widx;
  logic [DW-1:0]         mem [2**WW];
  stage_t                stage_q [LAT];
  stage_t                stage_d [LAT];
  logic [NP-1:0][DW-1:0] rdt_q, rdt_d;

  rp_arb #(.NP(NP), .ARB(ARB)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.req),
    .ack (ack)
  );

  assign bus.ack = ack;
  assign bus.rdt = rdt_q;

  // Mux the granted port's request fields onto one shared access path.
  always_comb begin
    xfer  = |(bus.req & ack);
    gidx  = '0;
    wen_g = 1'b0;
    sel_g = '0;
    adr_g = '0;
    wdt_g = '0;
    for (int i = 0; i < NP; i++) begin
      if (ack[i]) begin
        gidx  = IDW'(i);
        wen_g = bus.wen[i];
        sel_g = bus.sel[i];
        adr_g = bus.adr[i];
        wdt_g = bus.wdt[i];
      end
    end
    widx = adr_g[AW-1:OFS];
  end

  // Byte-lane writes; no write happens at an edge while reset is held.
  always_ff @(posedge clk) begin
    if (rst && xfer && wen_g) begin
      for (int b = 0; b < SW; b++) begin
        if (sel_g[b]) begin
          mem[widx][b*8 +: 8] <= wdt_g[b*8 +: 8];
        end
      end
    end
  end

  // Stage 0 samples the array at the transfer edge, later stages shift,
  // and the last stage lands in the rdt register of its port.
  always_comb begin
    stage_d[0].vld = xfer & ~wen_g;
    stage_d[0].id  = gidx;
    stage_d[0].dat = mem[widx];
    for (int k = 1; k < LAT; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    rdt_d = rdt_q;
    for (int i = 0; i < NP; i++) begin
      if (stage_q[LAT-1].vld && (stage_q[LAT-1].id == IDW'(i))) begin
        rdt_d[i] = stage_q[LAT-1].dat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LAT; k++) begin
        stage_q[k] <= '0;
      end
      rdt_q <= '0;
    end else begin
      for (int k = 0; k < LAT; k++) begin
        stage_q[k] <= stage_d[k];
      end
      rdt_q <= rdt_d;
    end
  end

endmodule

// File: tb/tb_rp_mem_mp.sv
// tb_rp_mem_mp: directed self-checking bench for rp_mem_mp.
// Six instances cover the configurations exercised: NP=2 RR LAT=1 (u_a),
// LAT=2 (u_l2), LAT=3 (u_l3), LAT=4 (u_l4), and NP=3 in RR and FIX mode.
module tb_rp_mem_mp;
  import rp_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rp_mem_mp_if #(.NP(2)) if_a ();
  rp_mem_mp_if #(.NP(2)) if_l2 ();
  rp_mem_mp_if #(.NP(2)) if_l3 ();
  rp_mem_mp_if #(.NP(2)) if_l4 ();
  rp_mem_mp_if #(.NP(3)) if_rr ();
  rp_mem_mp_if #(.NP(3)) if_fix ();

  rp_mem_mp #(.NP(2), .LAT(1), .ARB(RR))  u_a   (.clk(clk), .rst(rst), .bus(if_a.slave));
  rp_mem_mp #(.NP(2), .LAT(2), .ARB(RR))  u_l2  (.clk(clk), .rst(rst), .bus(if_l2.slave));
  rp_mem_mp #(.NP(2), .LAT(3), .ARB(RR))  u_l3  (.clk(clk), .rst(rst), .bus(if_l3.slave));
  rp_mem_mp #(.NP(2), .LAT(4), .ARB(RR))  u_l4  (.clk(clk), .rst(rst), .bus(if_l4.slave));
  rp_mem_mp #(.NP(3), .LAT(1), .ARB(RR))  u_rr  (.clk(clk), .rst(rst), .bus(if_rr.slave));
  rp_mem_mp #(.NP(3), .LAT(1), .ARB(FIX)) u_fix (.clk(clk), .rst(rst), .bus(if_fix.slave));

  // Expected rdt for the latency sweep: reads i=0,1,2 issued at edges 0,1,2
  // return i+1 at edge i+lat; before the first return rdt is still 0.
  function automatic logic [31:0] lat_exp(input int e, input int lat);
    int k;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      if (i + lat <= e) k++;
    end
    return 32'(k);
  endfunction

  task automatic init_inputs();
    if_a.req = '0;   if_a.wen = '0;   if_a.sel = '0;   if_a.adr = '0;   if_a.wdt = '0;
    if_l2.req = '0;  if_l2.wen = '0;  if_l2.sel = '0;  if_l2.adr = '0;  if_l2.wdt = '0;
    if_l3.req = '0;  if_l3.wen = '0;  if_l3.sel = '0;  if_l3.adr = '0;  if_l3.wdt = '0;
    if_l4.req = '0;  if_l4.wen = '0;  if_l4.sel = '0;  if_l4.adr = '0;  if_l4.wdt = '0;
    if_rr.req = '0;  if_rr.wen = '0;  if_rr.sel = '0;  if_rr.adr = '0;  if_rr.wdt = '0;
    if_fix.req = '0; if_fix.wen = '0; if_fix.sel = '0; if_fix.adr = '0; if_fix.wdt = '0;
  endtask

  // Single-port request on u_a, driven after the falling edge.
  task automatic a_xfer(input int p, input logic w, input logic [3:0] s,
                        input logic [15:0] ad, input logic [31:0] d);
    @(negedge clk);
    if_a.req    = '0;
    if_a.req[p] = 1'b1;
    if_a.wen[p] = w;
    if_a.sel[p] = s;
    if_a.adr[p] = ad;
    if_a.wdt[p] = d;
  endtask

  task automatic a_idle();
    @(negedge clk);
    if_a.req = '0;
  endtask

  // Port 0 request on the three latency-sweep instances in lockstep.
  task automatic lat_drive(input logic r, input logic w, input logic [15:0] ad,
                           input logic [31:0] d);
    if_a.req[0] = r;  if_a.wen[0] = w;  if_a.sel[0] = 4'hF;  if_a.adr[0] = ad;  if_a.wdt[0] = d;
    if_l2.req[0] = r; if_l2.wen[0] = w; if_l2.sel[0] = 4'hF; if_l2.adr[0] = ad; if_l2.wdt[0] = d;
    if_l4.req[0] = r; if_l4.wen[0] = w; if_l4.sel[0] = 4'hF; if_l4.adr[0] = ad; if_l4.wdt[0] = d;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (if_a.ack !== 2'b00) begin n_err++; $display("[TB] FAIL reset_ack_a: got %b expected 00", if_a.ack); end
    n_vec++; if (if_rr.ack !== 3'b000) begin n_err++; $display("[TB] FAIL reset_ack_rr: got %b expected 000", if_rr.ack); end
    n_vec++; if (if_a.rdt !== '0) begin n_err++; $display("[TB] FAIL reset_rdt_a: got %h expected 0", if_a.rdt); end
    n_vec++; if (if_l2.rdt !== '0) begin n_err++; $display("[TB] FAIL reset_rdt_l2: got %h expected 0", if_l2.rdt); end
    n_vec++; if (if_l3.rdt !== '0) begin n_err++; $display("[TB] FAIL reset_rdt_l3: got %h expected 0", if_l3.rdt); end
    n_vec++; if (if_l4.rdt !== '0) begin n_err++; $display("[TB] FAIL reset_rdt_l4: got %h expected 0", if_l4.rdt); end
    n_vec++; if (if_rr.rdt !== '0) begin n_err++; $display("[TB] FAIL reset_rdt_rr: got %h expected 0", if_rr.rdt); end
    n_vec++; if (if_fix.rdt !== '0) begin n_err++; $display("[TB] FAIL reset_rdt_fix: got %h expected 0", if_fix.rdt); end
    n_vec++; if (u_a.u_arb.ptr_q !== '0) begin n_err++; $display("[TB] FAIL reset_ptr_a: got %h expected 0", u_a.u_arb.ptr_q); end
    n_vec++; if (u_rr.u_arb.ptr_q !== '0) begin n_err++; $display("[TB] FAIL reset_ptr_rr: got %h expected 0", u_rr.u_arb.ptr_q); end
  endtask

  task automatic test_latency();
    logic [31:0] exp_v;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      lat_drive(1'b1, 1'b1, 16'(j * 4), 32'(j + 1));
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 3) lat_drive(1'b1, 1'b0, 16'(c * 4), 32'h0);
      else       lat_drive(1'b0, 1'b0, 16'h0, 32'h0);
      @(posedge clk);
      #1;
      exp_v = lat_exp(c, 1);
      n_vec++; if (if_a.rdt[0] !== exp_v) begin n_err++; $display("[TB] FAIL lat1_edge%0d: got %h expected %h", c, if_a.rdt[0], exp_v); end
      exp_v = lat_exp(c, 2);
      n_vec++; if (if_l2.rdt[0] !== exp_v) begin n_err++; $display("[TB] FAIL lat2_edge%0d: got %h expected %h", c, if_l2.rdt[0], exp_v); end
      exp_v = lat_exp(c, 4);
      n_vec++; if (if_l4.rdt[0] !== exp_v) begin n_err++; $display("[TB] FAIL lat4_edge%0d: got %h expected %h", c, if_l4.rdt[0], exp_v); end
    end
  endtask

  task automatic test_byte_lane();
    a_xfer(0, 1'b1, 4'b1111, 16'h0010, 32'hAABBCCDD);
    #1;
    n_vec++; if (if_a.ack !== 2'b01) begin n_err++; $display("[TB] FAIL bl_ack_w1: got %b expected 01", if_a.ack); end
    a_xfer(0, 1'b1, 4'b0101, 16'h0010, 32'h11223344);
    #1;
    n_vec++; if (if_a.ack !== 2'b01) begin n_err++; $display("[TB] FAIL bl_ack_w2: got %b expected 01", if_a.ack); end
    a_xfer(1, 1'b0, 4'b0000, 16'h0010, 32'h0);
    #1;
    n_vec++; if (if_a.ack !== 2'b10) begin n_err++; $display("[TB] FAIL bl_ack_rd: got %b expected 10", if_a.ack); end
    a_idle();
    n_vec++; if (if_a.rdt[1] !== 32'h0) begin n_err++; $display("[TB] FAIL bl_rdt_early: got %h expected 00000000", if_a.rdt[1]); end
    @(posedge clk);
    #1;
    n_vec++; if (if_a.rdt[1] !== 32'hAA22CC44) begin n_err++; $display("[TB] FAIL bl_rdt: got %h expected aa22cc44", if_a.rdt[1]); end
    n_vec++; if (if_a.rdt[0] !== 32'h3) begin n_err++; $display("[TB] FAIL bl_rdt_p0_hold: got %h expected 00000003", if_a.rdt[0]); end
  endtask

  task automatic test_read_after_write();
    a_xfer(1, 1'b1, 4'b1111, 16'h0100, 32'hDEADBEEF);
    #1;
    n_vec++; if (if_a.ack !== 2'b10) begin n_err++; $display("[TB] FAIL raw_ack_w: got %b expected 10", if_a.ack); end
    a_xfer(0, 1'b0, 4'b0000, 16'h0100, 32'h0);
    #1;
    n_vec++; if (if_a.ack !== 2'b01) begin n_err++; $display("[TB] FAIL raw_ack_r: got %b expected 01", if_a.ack); end
    a_idle();
    @(posedge clk);
    #1;
    n_vec++; if (if_a.rdt[0] !== 32'hDEADBEEF) begin n_err++; $display("[TB] FAIL raw_rdt: got %h expected deadbeef", if_a.rdt[0]); end
  endtask

  task automatic test_contention();
    logic [2:0] exp_rr;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if_rr.req  = 3'b111;
      if_fix.req = 3'b111;
      #1;
      exp_rr = 3'b001 << (i % 3);
      n_vec++; if (if_rr.ack !== exp_rr) begin n_err++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", i, if_rr.ack, exp_rr); end
      n_vec++; if (if_fix.ack !== 3'b001) begin n_err++; $display("[TB] FAIL fix_grant%0d: got %b expected 001", i, if_fix.ack); end
    end
    @(negedge clk);
    if_rr.req  = '0;
    if_fix.req = '0;
    #1;
    n_vec++; if (u_rr.u_arb.ptr_q !== 2'd0) begin n_err++; $display("[TB] FAIL rr_ptr_end: got %0d expected 0", u_rr.u_arb.ptr_q); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    if_l3.req[0] = 1'b1; if_l3.wen[0] = 1'b1; if_l3.sel[0] = 4'hF;
    if_l3.adr[0] = 16'h0020; if_l3.wdt[0] = 32'h5A5A5A5A;
    @(negedge clk);
    if_l3.wen[0] = 1'b0;
    #1;
    n_vec++; if (if_l3.ack !== 2'b01) begin n_err++; $display("[TB] FAIL mid_ack: got %b expected 01", if_l3.ack); end
    @(posedge clk);
    @(negedge clk);
    if_l3.req = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_vec++; if (if_l3.rdt[0] !== 32'h0) begin n_err++; $display("[TB] FAIL mid_rdt_in_reset: got %h expected 00000000", if_l3.rdt[0]); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_vec++; if (if_l3.rdt[0] !== 32'h0) begin n_err++; $display("[TB] FAIL mid_rdt_after%0d: got %h expected 00000000", c, if_l3.rdt[0]); end
    end
  endtask

  // Runs the scenarios in order; rdt of u_a port 0 carries over between them.
  initial begin
    init_inputs();
    test_reset();
    test_latency();
    test_byte_lane();
    test_read_after_write();
    test_contention();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
